// File: rtl/parity_bit_chk.sv
// parity_bit_chk: serial parity checker. It receives DATA_BITS data bits and
// then one parity bit, one bit per wr_en strobe. It reassembles the data word,
// checks the received parity bit against the parity of the data bits, and
// keeps a saturating count of frames that failed the check.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   data_in      in   serial bit, sampled when wr_en=1
//   wr_en        in   qualifies data_in for one cycle
//   frame_abort  in   synchronous; discards any partial frame
//   err_clr      in   synchronous; clears err_count
//   data_out     out  last completed data word, first-received bit in bit 0
//   frame_valid  out  one-cycle pulse when a frame completes
//   parity_err   out  1 when the last completed frame had a parity mismatch
//   err_count    out  saturating count of frames with a parity error
//   busy         out  high while a frame is partially received
module parity_bit_chk #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  input  logic                 wr_en,
  input  logic                 frame_abort,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 acc, acc_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_out_n;
  logic                 frame_valid_n;
  logic                 parity_err_n;
  logic [ERR_CNT_W-1:0] err_count_n;
  logic                 busy_n;
  logic                 err_c;

  // State and all outputs are registered from their next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      acc         <= 1'b0;
      shreg       <= '0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      err_count   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      acc         <= acc_n;
      shreg       <= shreg_n;
      data_out    <= data_out_n;
      frame_valid <= frame_valid_n;
      parity_err  <= parity_err_n;
      err_count   <= err_count_n;
      busy        <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    acc_n         = acc;
    shreg_n       = shreg;
    data_out_n    = data_out;
    frame_valid_n = 1'b0;
    parity_err_n  = parity_err;
    err_count_n   = err_count;
    err_c         = ((acc ^ data_in) != PARITY_ODD);

    // Abort beats a coincident strobe; that strobe's bit is dropped.
    if (frame_abort) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      acc_n     = 1'b0;
    end else if (wr_en) begin
      case (state)
        IDLE: begin
          // The word is rebuilt from scratch, so later bits can be OR-ed in.
          shreg_n   = DATA_BITS'(data_in);
          acc_n     = data_in;
          bit_cnt_n = CNT_W'(1);
          if (DATA_BITS == 1) state_n = PAR;
          else                state_n = DATA;
        end
        DATA: begin
          shreg_n   = shreg | (DATA_BITS'(data_in) << bit_cnt);
          acc_n     = acc ^ data_in;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt_n == CNT_W'(DATA_BITS)) state_n = PAR;
        end
        PAR: begin
          data_out_n    = shreg;
          parity_err_n  = err_c;
          frame_valid_n = 1'b1;
          if (err_c && (err_count != {ERR_CNT_W{1'b1}}))
            err_count_n = err_count + ERR_CNT_W'(1);
          state_n   = IDLE;
          bit_cnt_n = '0;
          acc_n     = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end

    // A clear wins over a coincident erroring completion.
    if (err_clr) err_count_n = '0;

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_parity_bit_chk.sv
// tb_parity_bit_chk: drives one even-parity checker (8-bit counter) and one
// odd-parity checker (2-bit counter) with identical stimulus. It compares both
// against a frame-level reference model on every cycle, and also checks
// hand-computed expectations for the directed scenarios.
module tb_parity_bit_chk;

  localparam int unsigned DB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic data_in = 1'b0;
  logic wr_en = 1'b0;
  logic frame_abort = 1'b0;
  logic err_clr = 1'b0;

  logic [7:0] do_e, do_o;
  logic       fv_e, fv_o, pe_e, pe_o, busy_e, busy_o;
  logic [7:0] ec_e;
  logic [1:0] ec_o;

  always #5 clk = ~clk;

  parity_bit_chk #(.DATA_BITS(8), .PARITY_ODD(1'b0), .ERR_CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en),
    .frame_abort(frame_abort), .err_clr(err_clr), .data_out(do_e),
    .frame_valid(fv_e), .parity_err(pe_e), .err_count(ec_e), .busy(busy_e)
  );

  parity_bit_chk #(.DATA_BITS(8), .PARITY_ODD(1'b1), .ERR_CNT_W(2)) u_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en),
    .frame_abort(frame_abort), .err_clr(err_clr), .data_out(do_o),
    .frame_valid(fv_o), .parity_err(pe_o), .err_count(ec_o), .busy(busy_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: bits of the current frame, plus per-DUT results.
  bit         q[$];
  logic [7:0] m_data[2];
  bit         m_valid[2];
  bit         m_perr[2];
  int         m_cnt[2];
  int         m_max[2] = '{255, 3};
  int         m_odd[2] = '{0, 1};

  typedef struct {
    logic [7:0] data;
    bit         par;
    int         gap;
    logic [7:0] exp_data;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int d = 0; d < 2; d++) begin
      m_data[d] = 8'h00; m_valid[d] = 1'b0; m_perr[d] = 1'b0; m_cnt[d] = 0;
    end
  endfunction

  function automatic void model_step(input bit wr, input bit din, input bit ab, input bit clr);
    logic [7:0] w;
    int ones;
    bit err;
    for (int d = 0; d < 2; d++) m_valid[d] = 1'b0;
    if (ab) begin
      q.delete();
    end else if (wr) begin
      if (q.size() == DB) begin
        w = 8'h00;
        for (int i = 0; i < DB; i++) w[i] = q[i];
        ones = $countones(w) + int'(din);
        for (int d = 0; d < 2; d++) begin
          err = ((ones % 2) != m_odd[d]);
          m_data[d] = w; m_perr[d] = err; m_valid[d] = 1'b1;
          if (err && m_cnt[d] < m_max[d]) m_cnt[d]++;
        end
        q.delete();
      end else begin
        q.push_back(din);
      end
    end
    if (clr) for (int d = 0; d < 2; d++) m_cnt[d] = 0;
  endfunction

  task automatic check_all();
    chk("even_data_out", do_e, m_data[0]);
    chk("even_frame_valid", fv_e, m_valid[0]);
    chk("even_parity_err", pe_e, m_perr[0]);
    chk("even_err_count", ec_e, m_cnt[0]);
    chk("even_busy", busy_e, q.size() != 0);
    chk("odd_data_out", do_o, m_data[1]);
    chk("odd_frame_valid", fv_o, m_valid[1]);
    chk("odd_parity_err", pe_o, m_perr[1]);
    chk("odd_err_count", ec_o, m_cnt[1]);
    chk("odd_busy", busy_o, q.size() != 0);
  endtask

  task automatic cycle(input bit wr, input bit din, input bit ab = 1'b0, input bit clr = 1'b0);
    wr_en = wr; data_in = din; frame_abort = ab; err_clr = clr;
    @(posedge clk);
    model_step(wr, din, ab, clr);
    #1;
    check_all();
    wr_en = 1'b0; frame_abort = 1'b0; err_clr = 1'b0;
  endtask

  // Send a full frame with 'gap' idle cycles after every data bit.
  task automatic send_frame(input logic [7:0] w, input bit p, input int gap, input bit clr_last = 1'b0);
    for (int i = 0; i < DB; i++) begin
      cycle(1'b1, w[i]);
      chk("busy_in_frame", busy_e, 1'b1);
      for (int g = 0; g < gap; g++) begin
        cycle(1'b0, 1'b0);
        chk("busy_in_gap", busy_e, 1'b1);
      end
    end
    cycle(1'b1, p, 1'b0, clr_last);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_data_out"}, do_e, 8'h00);
    chk({tag, "_frame_valid"}, fv_e, 1'b0);
    chk({tag, "_parity_err"}, pe_e, 1'b0);
    chk({tag, "_err_count"}, ec_e, 8'h00);
    chk({tag, "_busy"}, busy_e, 1'b0);
    chk({tag, "_odd_err_count"}, ec_o, 2'd0);
    chk({tag, "_odd_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'h00, 1'b0, 0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 1'b0, 1, 8'hFF, 1'b0};
    vecs[2] = '{8'h80, 1'b0, 2, 8'h80, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 0, 8'h3C, 1'b1};
    vecs[4] = '{8'h7F, 1'b1, 0, 8'h7F, 1'b0};
    vecs[5] = '{8'h55, 1'b0, 1, 8'h55, 1'b0};

    // Reset.
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // 1: good frame, no gaps.
    send_frame(8'hA5, 1'b0, 0);
    chk("t1_frame_valid", fv_e, 1'b1);
    chk("t1_data_out", do_e, 8'hA5);
    chk("t1_parity_err", pe_e, 1'b0);
    chk("t1_err_count", ec_e, 8'd0);
    cycle(1'b0, 1'b0);
    chk("t1_valid_one_cycle", fv_e, 1'b0);

    // 2: bad parity bit with 3-cycle gaps.
    send_frame(8'hA5, 1'b1, 3);
    chk("t2_parity_err", pe_e, 1'b1);
    chk("t2_err_count", ec_e, 8'd1);
    chk("t2_busy_fall", busy_e, 1'b0);

    // 3: odd parity, back to back.
    send_frame(8'h01, 1'b0, 0);
    chk("t3a_frame_valid", fv_o, 1'b1);
    chk("t3a_data_out", do_o, 8'h01);
    chk("t3a_parity_err", pe_o, 1'b0);
    send_frame(8'hFF, 1'b1, 0);
    chk("t3b_frame_valid", fv_o, 1'b1);
    chk("t3b_data_out", do_o, 8'hFF);
    chk("t3b_parity_err", pe_o, 1'b0);

    // 4: abort after 5 bits with a coincident strobe.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'(i & 1));
    cycle(1'b1, 1'b1, 1'b1);
    chk("t4_abort_busy", busy_e, 1'b0);
    chk("t4_abort_no_valid", fv_e, 1'b0);
    send_frame(8'h3C, 1'b0, 0);
    chk("t4_data_out", do_e, 8'h3C);
    chk("t4_parity_err", pe_e, 1'b0);
    chk("t4_err_count", ec_e, 8'd3);

    // 5: saturation and clear on the 2-bit counter.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_cleared", ec_o, 2'd0);
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h00, 1'b0, 0);
      chk("t5_sat_count", ec_o, (k < 3) ? 2'(k + 1) : 2'd3);
    end
    send_frame(8'h00, 1'b0, 0, 1'b1);
    chk("t5_clr_wins", ec_o, 2'd0);
    chk("t5_parity_err", pe_o, 1'b1);

    // Table-driven frames on the even checker.
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].gap);
      chk("vec_data_out", do_e, vecs[i].exp_data);
      chk("vec_parity_err", pe_e, vecs[i].exp_err);
      chk("vec_frame_valid", fv_e, 1'b1);
    end

    // 6: reset mid-frame.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("t6_rst_async");
    @(posedge clk);
    #1;
    check_reset_values("t6_rst_held");
    rst_n = 1'b1;
    send_frame(8'h80, 1'b1, 0);
    chk("t6_data_out", do_e, 8'h80);
    chk("t6_parity_err", pe_e, 1'b0);
    chk("t6_frame_valid", fv_e, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 9) < 7, 1'($urandom),
            $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_bit_chk.md
# parity_bit_chk

Serial parity checker that receives a frame of `DATA_BITS` data bits followed by one parity bit, one bit per `wr_en` strobe. It reassembles the data word, compares the received parity bit against the parity computed over the data bits, and flags mismatches. It also keeps a saturating error count. It sits at the receiving end of a link whose transmitter accumulates parity with the team's serial parity generator and appends that bit after the data.

## Interface

Clock is `clk`. Reset is `rst_n`, asynchronous and active-low.

Parameters:
- `DATA_BITS`, default 8: data bits per frame, excluding parity. Legal range 1 to 32.
- `PARITY_ODD`, default 1'b0: 0 means even parity is expected; 1 means odd parity is expected.
- `ERR_CNT_W`, default 8: width of the error counter.

Ports:
- `clk`  input  1: clock; all logic on the rising edge.
- `rst_n`  input  1: asynchronous active-low reset.
- `data_in`  input  1: serial bit, sampled only when `wr_en`=1.
- `wr_en`  input  1: qualifies `data_in` for one cycle; gaps between strobes are allowed.
- `frame_abort`  input  1: synchronous; discards any partial frame.
- `err_clr`  input  1: synchronous; clears `err_count`.
- `data_out`  output  `DATA_BITS`: last completed data word, first-received bit in bit 0.
- `frame_valid`  output  1: one-cycle pulse when a frame completes.
- `parity_err`  output  1: result for the last completed frame; 1 means mismatch.
- `err_count`  output  `ERR_CNT_W`: number of frames with a parity error, saturating.
- `busy`  output  1: high while a frame is partially received.

## Operation

- State machine with three states: IDLE, DATA, PAR.
  - IDLE: `wr_en`=1 captures the first data bit, sets the bit count to 1 and loads `acc` with `data_in`. The next state is DATA, or PAR if `DATA_BITS`=1.
  - DATA: each `wr_en`=1 shifts `data_in` into the shift register at position `bit_cnt`, XORs it into `acc` and increments `bit_cnt`. When `bit_cnt` reaches `DATA_BITS`, the next state is PAR.
  - PAR: `wr_en`=1 treats `data_in` as the parity bit and completes the frame. The next state is IDLE.
- Parity rule: `err = ((acc ^ data_in) != PARITY_ODD)`. For even parity, the XOR of all data bits plus the parity bit must be 0; for odd parity, it must be 1.
- On frame completion:
  - `data_out` is loaded with the assembled word.
  - `parity_err` is set to `err`.
  - `frame_valid` pulses.
  - If `err`=1, `err_count` is incremented unless it is already all ones, in which case it holds.
- `data_out` and `parity_err` hold their values until the next completed frame. They are not changed by abort.
- `frame_abort`=1 in any state returns the machine to IDLE and clears `bit_cnt` and `acc`. No `frame_valid` is produced. It has priority over a coincident `wr_en`, whose bit is dropped. It has no effect on `data_out`, `parity_err` or `err_count`.
- `err_clr`=1 sets `err_count` to 0. If it coincides with an erroring frame completion, the clear wins and the count is 0.
- `busy` = (state != IDLE).
- `wr_en`=0 means every register holds its value, except that `frame_valid` returns to 0.

## Timing

- Reset values of all outputs:
  - `data_out` = 0
  - `frame_valid` = 0
  - `parity_err` = 0
  - `err_count` = 0
  - `busy` = 0
  - Internally: state = IDLE, `bit_cnt` = 0, `acc` = 0.
- Reset asserted mid-frame discards the partial frame immediately. The first `wr_en` after reset release is data bit 0.
- Latency: all outputs are registered. `data_out`, `parity_err`, `err_count` and `frame_valid` all update on the edge that samples the parity bit. `frame_valid` is high for exactly the following cycle.
- Back-to-back frames are supported. A `wr_en` during the `frame_valid` cycle is data bit 0 of the next frame. The minimum frame time is `DATA_BITS`+1 cycles.
- `busy` rises on the edge that samples data bit 0. It falls on the edge that samples the parity bit or on an abort.

## Test plan

1. **Good frame, no gaps.** With `DATA_BITS`=8 and even parity, send 0xA5 LSB first (1,0,1,0,0,1,0,1) then parity 0, with `wr_en` continuous. Required: `frame_valid` for one cycle, `data_out`=0xA5, `parity_err`=0, `err_count`=0.
2. **Bad parity bit, with gaps.** Send 0xA5 then parity 1, inserting 3 idle cycles between bits. Required: `parity_err`=1, `err_count`=1, `busy` high from bit 0 until the parity edge.
3. **Odd parity, back to back.** With `PARITY_ODD`=1, send 0x01 with parity 0, then immediately 0xFF with parity 1. Required: two `frame_valid` pulses, `parity_err` 0 and then 0, `data_out` 0x01 and then 0xFF.
4. **Abort mid-frame.** Abort after 5 bits with `wr_en` also high in that cycle, then send 0x3C with parity 0. Required: no pulse for the aborted frame, `data_out`=0x3C, `parity_err`=0, and the previous `err_count` unchanged.
5. **Saturation and clear.** With `ERR_CNT_W`=2, send 4 bad frames. Required: `err_count` goes 1, 2, 3, 3. Then assert `err_clr` coincident with a 5th bad frame completion. Required: `err_count`=0 and `parity_err`=1.
6. **Reset mid-frame.** Assert `rst_n` low after 4 bits, then release and send 0x80 with parity 1. Required: all outputs at reset values during reset, then `data_out`=0x80 and `parity_err`=0.
